instr_sequencer: RTL

//   Fetch/execute sequencer for the 16-bit CPU, upstream of the instruction decoder.

---
 rtl/instr_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: loads the IR from instruction RAM and drives the one-hot FETCH/EXEC1/EXEC2 strobes.
// Optional single-step gating of FETCH is enabled by defining SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int CNT_W          = 16,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             START,
  input  logic [15:0]      RAMi_q,
  input  logic             E2,
  input  logic             STP,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             STEP,
`endif
  output logic [15:0]      instr,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  state_t state;
  state_t nxt;
  logic   step_go;
  logic   retire;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) step_q <= 1'b0;
    else         step_q <= STEP;
  end

  // One rising edge of STEP releases exactly one instruction.
  assign step_go = STEP & ~step_q;
`else
  assign step_go = 1'b1;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (START || START_ON_RESET) nxt = S_FETCH;
      S_FETCH: if (step_go) nxt = S_EXEC1;
      S_EXEC1: begin
        if (STP)     nxt = S_HALT;
        else if (E2) nxt = S_EXEC2;
        else         nxt = S_FETCH;
      end
      S_EXEC2: nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  // An instruction retires on the edge leaving its last execute cycle, STP included.
  assign retire = (state == S_EXEC2) || ((state == S_EXEC1) && (nxt != S_EXEC2));

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking assignments.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      instr     <= 16'h0000;
      INSTR_CNT <= '0;
      FETCH     <= 1'b0;
      EXEC1     <= 1'b0;
      EXEC2     <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      state  <= nxt;
      FETCH  <= (nxt == S_FETCH);
      EXEC1  <= (nxt == S_EXEC1);
      EXEC2  <= (nxt == S_EXEC2);
      HALTED <= (nxt == S_HALT);
      if ((state == S_FETCH) && step_go) instr <= RAMi_q;
      if (retire) INSTR_CNT <= INSTR_CNT + CNT_W'(1);
    end
  end

endmodule
